// File: rtl/tone_pkg.sv
// tone_pkg: widths, tone FSM states and note divisors shared with the number-to-frequency stage
package tone_pkg;

    localparam int DIV_W      = 15;
    localparam int MIN_DIV    = 2;
    localparam int GAP_CYCLES = 50000;

    typedef enum logic [1:0] {IDLE, PLAY, STOP, GAP} state_t;

    localparam logic [DIV_W-1:0] NOTE_1K = 15'd25000;
    localparam logic [DIV_W-1:0] NOTE_2K = 15'd12500;
    localparam logic [DIV_W-1:0] NOTE_3K = 15'd8333;
    localparam logic [DIV_W-1:0] NOTE_4K = 15'd6250;

endpackage

// File: rtl/tone_square_gen_half_period_counter.sv
// half_period_counter: counts clocks inside one half period and re-latches the divisor at each boundary (TONE_GAP_EN adds a divisor-change flag)
module half_period_counter #(
    parameter int           W       = 15,
    parameter logic [W-1:0] RST_DIV = W'(2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         load,
    input  logic [W-1:0] eff_div,
`ifdef TONE_GAP_EN
    output logic         changing,
`endif
    output logic         boundary
);

    logic [W-1:0] cnt;
    logic [W-1:0] div_q;

    assign boundary = run && (cnt == div_q - W'(1));
`ifdef TONE_GAP_EN
    assign changing = (eff_div != div_q);
`endif

    // restart on load, wrap and take the new divisor at a boundary, hold cleared while stopped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= RST_DIV;
        end else if (load) begin
            cnt   <= '0;
            div_q <= eff_div;
        end else if (boundary) begin
            cnt   <= '0;
            div_q <= eff_div;
        end else if (run) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/tone_square_gen.sv
// tone_square_gen: glitch-free square wave from a half-period count; TONE_GAP_EN inserts a silent gap on note changes
module tone_square_gen #(
  parameter int DIV_W      = tone_pkg::DIV_W,
  parameter int GAP_CYCLES = tone_pkg::GAP_CYCLES,
  parameter int MIN_DIV    = tone_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] frequency,
  input  logic             play,
  output logic             speaker,
  output logic             busy,
  output logic             period_tick
);
  import tone_pkg::*;
  localparam logic [DIV_W-1:0] MIN_Q = DIV_W'(MIN_DIV);
  state_t           state;
  logic [DIV_W-1:0] eff_div;
  logic             tone_run;
  logic             tone_load;
  logic             tone_bnd;
  assign eff_div  = (frequency < MIN_Q) ? MIN_Q : frequency;
  assign tone_run = (state == PLAY) || (state == STOP);
`ifdef TONE_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic tone_chg;
  logic gap_bnd;
  logic gap_stop;
  assign tone_load = ((state == IDLE) && play) || gap_bnd;
  half_period_counter #(
    .W       (GAP_W),
    .RST_DIV (GAP_W'(GAP_CYCLES))
  ) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (state == GAP),
    .load     (1'b0),
    .eff_div  (GAP_W'(GAP_CYCLES)),
    .changing (),
    .boundary (gap_bnd)
  );
`else
  assign tone_load = (state == IDLE) && play;
`endif
  half_period_counter #(
    .W       (DIV_W),
    .RST_DIV (MIN_Q)
  ) u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (tone_run),
    .load     (tone_load),
    .eff_div  (eff_div),
`ifdef TONE_GAP_EN
    .changing (tone_chg),
`endif
    .boundary (tone_bnd)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      speaker     <= 1'b0;
      busy        <= 1'b0;
      period_tick <= 1'b0;
`ifdef TONE_GAP_EN
      gap_stop    <= 1'b0;
`endif
    end else begin
      period_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (play) begin
            state   <= PLAY;
            speaker <= 1'b1;
            busy    <= 1'b1;
          end
        end
        PLAY: begin
          if (tone_bnd) begin
            speaker     <= ~speaker;
            period_tick <= speaker;
          end
`ifdef TONE_GAP_EN
          if (tone_bnd && speaker && tone_chg) begin
            state    <= GAP;
            gap_stop <= !play;
          end else if (!play) begin
            state <= STOP;
          end
`else
          if (!play)
            state <= STOP;
`endif
        end
        STOP: begin
          if (tone_bnd) begin
            speaker     <= ~speaker;
            period_tick <= speaker;
          end
          if (play) begin
            state <= PLAY;
          end else if (tone_bnd) begin
            state   <= IDLE;
            busy    <= 1'b0;
            speaker <= 1'b0;
          end
        end
`ifdef TONE_GAP_EN
        GAP: begin
          if (!play)
            gap_stop <= 1'b1;
          if (gap_bnd) begin
            state   <= (gap_stop || !play) ? IDLE : PLAY;
            speaker <= !(gap_stop || !play);
            busy    <= !(gap_stop || !play);
          end
        end
`endif
        default: begin
          state   <= IDLE;
          speaker <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tone_square_gen.sv
// tb_tone_square_gen: directed checks of the square-wave tone generator (gap timing checked when TONE_GAP_EN is set)
module tb_tone_square_gen;
  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        play      = 1'b0;
  logic [14:0] frequency = '0;
  logic        speaker;
  logic        busy;
  logic        period_tick;
  int          total = 0;
  int          bad   = 0;
`ifdef TONE_GAP_EN
  localparam int GAPN = 10;
`else
  localparam int GAPN = 0;
`endif
  localparam int LO_END = 4 + ((GAPN != 0) ? GAPN : 6);
  always #5 clk = ~clk;
  tone_square_gen #(.GAP_CYCLES(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frequency   (frequency),
    .play        (play),
    .speaker     (speaker),
    .busy        (busy),
    .period_tick (period_tick)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic restart();
    rst_n = 1'b0;
    play  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask
  initial begin
    step();
    step();
    check("rst spk", 32'(speaker), 0);
    check("rst busy", 32'(busy), 0);
    check("rst tick", 32'(period_tick), 0);
    rst_n = 1'b1;
    step();
    step();
    check("idle spk", 32'(speaker), 0);
    check("idle busy", 32'(busy), 0);
    frequency = 15'd4;
    play      = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      check($sformatf("f4 spk %0d", i), 32'(speaker), 32'(((i - 1) / 4) % 2 == 0));
      check($sformatf("f4 tick %0d", i), 32'(period_tick), 32'((i - 1) % 8 == 4));
      check($sformatf("f4 busy %0d", i), 32'(busy), 1);
    end
    play = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("f4 stop spk %0d", i), 32'(speaker), 32'(i < 5));
      check($sformatf("f4 stop tick %0d", i), 32'(period_tick), 32'(i == 5));
      check($sformatf("f4 stop busy %0d", i), 32'(busy), 32'(i < 5));
    end
    restart();
    frequency = 15'd0;
    play      = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("clamp spk %0d", i), 32'(speaker), 32'(((i - 1) / 2) % 2 == 0));
      check($sformatf("clamp tick %0d", i), 32'(period_tick), 32'((i - 1) % 4 == 2));
      if (i == 8)
        frequency = 15'd1;
    end
    restart();
    frequency = 15'd4;
    play      = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      step();
      check($sformatf("chg spk %0d", i), 32'(speaker),
            (i <= 4) ? 1 : (i <= LO_END) ? 0 : 32'(((i - LO_END - 1) / 6) % 2 == 0));
      check($sformatf("chg tick %0d", i), 32'(period_tick), 32'(i == 5 || i == LO_END + 7));
      if (i == 2)
        frequency = 15'd6;
    end
    restart();
    frequency = 15'd5;
    play      = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("stop5 spk %0d", i), 32'(speaker), 32'(i <= 5));
      check($sformatf("stop5 busy %0d", i), 32'(busy), 32'(i <= 5));
      check($sformatf("stop5 tick %0d", i), 32'(period_tick), 32'(i == 6));
      if (i == 1)
        play = 1'b0;
    end
    restart();
    frequency = 15'd2;
    play      = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("stoplo spk %0d", i), 32'(speaker), 32'(i <= 2));
      check($sformatf("stoplo tick %0d", i), 32'(period_tick), 32'(i == 3));
      check($sformatf("stoplo busy %0d", i), 32'(busy), 32'(i <= 4));
      if (i == 3)
        play = 1'b0;
    end
    restart();
    frequency = 15'd3;
    play      = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("resume spk %0d", i), 32'(speaker), 32'(((i - 1) / 3) % 2 == 0));
      check($sformatf("resume tick %0d", i), 32'(period_tick), 32'((i - 1) % 6 == 3));
      check($sformatf("resume busy %0d", i), 32'(busy), 1);
      if (i == 2)
        play = 1'b0;
      if (i == 3)
        play = 1'b1;
    end
    restart();
    frequency = 15'd6;
    play      = 1'b1;
    step();
    step();
    check("arst pre spk", 32'(speaker), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst spk", 32'(speaker), 0);
    check("arst busy", 32'(busy), 0);
    check("arst tick", 32'(period_tick), 0);
    play = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("post rst spk %0d", i), 32'(speaker), 0);
      check($sformatf("post rst busy %0d", i), 32'(busy), 0);
    end
    play = 1'b1;
    step();
    check("replay spk", 32'(speaker), 1);
    check("replay busy", 32'(busy), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
